// File: rtl/axil_regbus_bridge.sv
// AXI4-Lite slave to register-bus master bridge: one-entry AW/W/AR buffers,
// one regbus access at a time, with timeout and read/write arbitration.
module axil_regbus_bridge #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = 32'hDEADDEAD,
    parameter bit                ARB_RR         = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                addr_valid,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   reg_addr,
    output logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W/8-1:0] reg_wstrb,
    input  logic [DATA_W-1:0]   reg_rdata,
    input  logic                reg_ready,
    output logic [15:0]         timeout_cnt
);
    localparam int          STRB_W  = DATA_W / 8;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg;
    logic                aw_full_reg, w_full_reg, ar_full_reg;
    logic                aw_full_next, w_full_next, ar_full_next;
    logic [ADDR_W-1:0]   aw_addr_reg, ar_addr_reg;
    logic [DATA_W-1:0]   w_data_reg;
    logic [STRB_W-1:0]   w_strb_reg;
    logic                last_grant_rd_reg;
    logic                cur_write_reg;
    logic [15:0]         cnt_reg;

    logic aw_hs, w_hs, ar_hs;
    logic resp_done, free_wr, free_rd;
    logic wr_elig, rd_elig, grant_any, grant_wr;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    assign resp_done = (state_reg == RESP) &&
                       ((cur_write_reg && s_bvalid && s_bready) ||
                        (!cur_write_reg && s_rvalid && s_rready));
    assign free_wr = resp_done && cur_write_reg;
    assign free_rd = resp_done && !cur_write_reg;

    // A buffer stays full through ACCESS and RESP so its ready holds off the master.
    assign aw_full_next = aw_hs || (aw_full_reg && !free_wr);
    assign w_full_next  = w_hs  || (w_full_reg  && !free_wr);
    assign ar_full_next = ar_hs || (ar_full_reg && !free_rd);

    assign wr_elig   = aw_full_reg && w_full_reg;
    assign rd_elig   = ar_full_reg;
    assign grant_any = wr_elig || rd_elig;
    assign grant_wr  = wr_elig && (!rd_elig || !ARB_RR || last_grant_rd_reg);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            ar_full_reg <= 1'b0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_arready   <= 1'b0;
            aw_addr_reg <= '0;
            ar_addr_reg <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
        end else begin
            aw_full_reg <= aw_full_next;
            w_full_reg  <= w_full_next;
            ar_full_reg <= ar_full_next;
            s_awready   <= !aw_full_next;
            s_wready    <= !w_full_next;
            s_arready   <= !ar_full_next;
            if (aw_hs) aw_addr_reg <= s_awaddr;
            if (ar_hs) ar_addr_reg <= s_araddr;
            if (w_hs) begin
                w_data_reg <= s_wdata;
                w_strb_reg <= s_wstrb;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg         <= IDLE;
            last_grant_rd_reg <= 1'b1;
            cur_write_reg     <= 1'b0;
            cnt_reg           <= '0;
            addr_valid        <= 1'b0;
            reg_write         <= 1'b0;
            reg_addr          <= '0;
            reg_wdata         <= '0;
            reg_wstrb         <= '0;
            s_bvalid          <= 1'b0;
            s_bresp           <= '0;
            s_rvalid          <= 1'b0;
            s_rresp           <= '0;
            s_rdata           <= '0;
            timeout_cnt       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        state_reg     <= ACCESS;
                        addr_valid    <= 1'b1;
                        cur_write_reg <= grant_wr;
                        reg_write     <= grant_wr;
                        reg_addr      <= grant_wr ? aw_addr_reg : ar_addr_reg;
                        reg_wdata     <= w_data_reg;
                        reg_wstrb     <= grant_wr ? w_strb_reg : '0;
                        cnt_reg       <= '0;
                    end
                end
                ACCESS: begin
                    // A completion arriving on the last allowed cycle still counts as OKAY.
                    if (reg_ready) begin
                        addr_valid <= 1'b0;
                        state_reg  <= RESP;
                        if (cur_write_reg) begin
                            s_bvalid <= 1'b1;
                            s_bresp  <= OKAY;
                        end else begin
                            s_rvalid <= 1'b1;
                            s_rresp  <= OKAY;
                            s_rdata  <= reg_rdata;
                        end
                    end else if (cnt_reg == TO_LAST) begin
                        addr_valid <= 1'b0;
                        state_reg  <= RESP;
                        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                        if (cur_write_reg) begin
                            s_bvalid <= 1'b1;
                            s_bresp  <= SLVERR;
                        end else begin
                            s_rvalid <= 1'b1;
                            s_rresp  <= SLVERR;
                            s_rdata  <= TIMEOUT_RDATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        s_bvalid          <= 1'b0;
                        s_rvalid          <= 1'b0;
                        last_grant_rd_reg <= !cur_write_reg;
                        state_reg         <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
